reorder_buffer: RTL and testbench
=================================

REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter ROB_SIZE, default 15, meaning usable entries; tags 1..15, tag 0 (ZERO_ROB) means "none".
REQ-002 SHALL have ports, clock and reset first:
 clk  in  1  single clock, all state on rising edge.
 rst  in  1  reset, asynchronous, active-low.
 rdy  in  1  low = hold all state, no pulses.
 in_dcd_op  in  6  issue opcode enum; OPENUM_NOP = no issue.
 in_dcd_dest  in  5  destination register; 0 = none.
 in_dcd_pc  in  32  instruction PC.
 in_dcd_jump_flag  in  1  predicted taken.
 out_freetag  out  4  tail tag if not full, else ZERO_ROB (combinational).
 out_full  out  1  count == ROB_SIZE.
 in_fetch_tag1/2  in  4  operand query tags.
 out_fetch_value1/2  out  32  query value (combinational).
 out_fetch_ready1/2  out  1  query value valid.
 in_alu_tag  in  4  ALU broadcast tag; 0 = idle.
 in_alu_value  in  32  ALU result.
 in_alu_taken  in  1  actual branch outcome.
 in_alu_target  in  32  actual branch/jump target.
 in_lsb_tag  in  4  LSB broadcast tag; 0 = idle.
 in_lsb_value  in  32  load data (ignored for stores).
 out_commit_dest  out  5  register to write; 0 = no write.
 out_commit_tag  out  4  tag retiring (register busy-clear match).
 out_commit_value  out  32  value retiring.
 out_store_commit_tag  out  4  store allowed to write memory; 0 = none.
 out_flush  out  1  one-cycle mispredict flush.
 out_redirect_pc  out  32  fetch restart PC, valid with out_flush.

Function
REQ-003 SHALL hold a circular buffer, head/tail pointers in 1..ROB_SIZE, wrap ROB_SIZE -> 1, and count 0..ROB_SIZE.
REQ-004 Issue SHALL occur when op != NOP, count < ROB_SIZE (pre-edge), no flush this edge, rdy high: entry gets busy=1, ready=0, op/dest/pc/predicted; tail advances.
REQ-005 A broadcast on a nonzero tag of a busy entry SHALL set ready=1 and latch value; ALU also latches taken/target; ALU and LSB on different tags same cycle both apply.
REQ-006 Query SHALL return ready=1 if entry ready, or if tag matches this cycle's ALU/LSB broadcast (bypass, ALU first); tag 0 or non-busy entry SHALL return ready=0, value 0.
REQ-007 Commit SHALL retire at most one entry per cycle: head busy and ready; commit outputs registered, valid exactly one cycle, else zero.
REQ-008 Non-branch retire SHALL drive dest/tag/value; store retire (OPENUM_SB/SH/SW) SHALL drive out_store_commit_tag only, dest 0.
REQ-009 Branch retire SHALL compare taken vs predicted; mismatch -> out_flush=1, out_redirect_pc = taken ? target : pc+4. JALR SHALL always flush to target; JAL/JALR also commit dest with value.
REQ-010 Flush edge SHALL clear all busy bits, head=tail=1, count=0; same-cycle issue and broadcasts discarded.
REQ-011 Simultaneous issue and commit SHALL leave count unchanged; full blocks issue even if committing.
REQ-012 Empty ROB: no commit outputs; out_freetag = tail.

Reset
REQ-013 rst low SHALL immediately set head=tail=1, count=0, busy all 0, every output register 0; out_freetag = 1 after release.
REQ-014 Reset mid-operation SHALL discard all entries with no commit or flush pulse.

Structure
REQ-015 Widths, ZERO_ROB, ZERO_REG, ROB_SIZE and OPENUM codes SHALL live in the shared definitions package.
REQ-016 One combinational sub-module rob_op_class SHALL classify op into is_branch, is_store, is_jalr.

Verification
REQ-017 Issue ADD dest=5 tag1; ALU tag1 value 0x2A -> next cycle commit dest=5 tag=1 value=0x2A.
REQ-018 Issue 15 NOPs-free ops -> out_full=1, out_freetag=0, 16th issue ignored; retire one -> freetag=1 (wrap).
REQ-019 Query tag3 same cycle as ALU tag3 value 0x77 -> ready=1 value 0x77.
REQ-020 BEQ pc=0x100 predicted taken, ALU taken=0 -> out_flush=1, redirect=0x104, younger entries gone, freetag=1.
REQ-021 SW tag2 ready via LSB -> out_store_commit_tag=2, out_commit_dest=0.
REQ-022 rst low with 4 entries pending -> all outputs 0, count 0, no commit after release.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// reorder_buffer_pkg: shared widths, tag/register constants, opcodes and pointer helper
package reorder_buffer_pkg;
    localparam int ROB_SIZE = 15;
    localparam int TAG_W = 4;
    localparam int REG_W = 5;
    localparam int OP_W = 6;
    localparam int XLEN = 32;
    localparam logic [TAG_W-1:0] ZERO_ROB = '0;
    localparam logic [REG_W-1:0] ZERO_REG = '0;
    typedef enum logic [OP_W-1:0] {
        OPENUM_NOP, OPENUM_LUI, OPENUM_AUIPC, OPENUM_JAL, OPENUM_JALR,
        OPENUM_BEQ, OPENUM_BNE, OPENUM_BLT, OPENUM_BGE, OPENUM_BLTU, OPENUM_BGEU,
        OPENUM_LB, OPENUM_LH, OPENUM_LW, OPENUM_LBU, OPENUM_LHU,
        OPENUM_SB, OPENUM_SH, OPENUM_SW,
        OPENUM_ADDI, OPENUM_SLTI, OPENUM_SLTIU, OPENUM_XORI, OPENUM_ORI,
        OPENUM_ANDI, OPENUM_SLLI, OPENUM_SRLI, OPENUM_SRAI,
        OPENUM_ADD, OPENUM_SUB, OPENUM_SLL, OPENUM_SLT, OPENUM_SLTU,
        OPENUM_XOR, OPENUM_SRL, OPENUM_SRA, OPENUM_OR, OPENUM_AND
    } openum_e;
    function automatic logic [TAG_W-1:0] rob_next(input logic [TAG_W-1:0] p, input int size);
        return (int'(p) == size) ? TAG_W'(1) : p + TAG_W'(1);
    endfunction
endpackage

// File: rtl/reorder_buffer_op_class.sv
// rob_op_class: decodes an opcode into branch / store / jalr retire classes
module rob_op_class
    import reorder_buffer_pkg::*;
(
    input  logic [OP_W-1:0] op,
    output logic            is_branch,
    output logic            is_store,
    output logic            is_jalr
);
    assign is_branch = op inside {OPENUM_BEQ, OPENUM_BNE, OPENUM_BLT, OPENUM_BGE, OPENUM_BLTU, OPENUM_BGEU};
    assign is_store = op inside {OPENUM_SB, OPENUM_SH, OPENUM_SW};
    assign is_jalr = op == OPENUM_JALR;
endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retire queue with result broadcast, operand bypass and mispredict flush
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_SIZE = reorder_buffer_pkg::ROB_SIZE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic [OP_W-1:0]  in_dcd_op,
    input  logic [REG_W-1:0] in_dcd_dest,
    input  logic [XLEN-1:0]  in_dcd_pc,
    input  logic             in_dcd_jump_flag,
    output logic [TAG_W-1:0] out_freetag,
    output logic             out_full,
    input  logic [TAG_W-1:0] in_fetch_tag1,
    input  logic [TAG_W-1:0] in_fetch_tag2,
    output logic [XLEN-1:0]  out_fetch_value1,
    output logic [XLEN-1:0]  out_fetch_value2,
    output logic             out_fetch_ready1,
    output logic             out_fetch_ready2,
    input  logic [TAG_W-1:0] in_alu_tag,
    input  logic [XLEN-1:0]  in_alu_value,
    input  logic             in_alu_taken,
    input  logic [XLEN-1:0]  in_alu_target,
    input  logic [TAG_W-1:0] in_lsb_tag,
    input  logic [XLEN-1:0]  in_lsb_value,
    output logic [REG_W-1:0] out_commit_dest,
    output logic [TAG_W-1:0] out_commit_tag,
    output logic [XLEN-1:0]  out_commit_value,
    output logic [TAG_W-1:0] out_store_commit_tag,
    output logic             out_flush,
    output logic [XLEN-1:0]  out_redirect_pc
);
    localparam int CNT_W = $clog2(ROB_SIZE + 1);
    logic [TAG_W-1:0] head, tail;
    logic [CNT_W-1:0] count;
    logic [ROB_SIZE:0] busy, ready;
    logic [OP_W-1:0]  op_q     [0:ROB_SIZE];
    logic [REG_W-1:0] dest_q   [0:ROB_SIZE];
    logic [XLEN-1:0]  pc_q     [0:ROB_SIZE];
    logic [XLEN-1:0]  val_q    [0:ROB_SIZE];
    logic [XLEN-1:0]  target_q [0:ROB_SIZE];
    logic [ROB_SIZE:0] pred_q, taken_q;
    logic full, do_commit, mispredict, flush, do_issue, alu_hit, lsb_hit, wr_reg;
    logic h_branch, h_store, h_jalr;
    logic [XLEN-1:0] redirect;
    rob_op_class u_op_class (
        .op       (op_q[head]),
        .is_branch(h_branch),
        .is_store (h_store),
        .is_jalr  (h_jalr)
    );
    assign full = count == CNT_W'(ROB_SIZE);
    assign out_full = full;
    assign out_freetag = full ? ZERO_ROB : tail;
    assign do_commit = rdy && busy[head] && ready[head];
    assign mispredict = h_jalr || (h_branch && (taken_q[head] != pred_q[head]));
    assign flush = do_commit && mispredict;
    assign do_issue = rdy && in_dcd_op != OPENUM_NOP && !full && !flush;
    assign alu_hit = rdy && busy[in_alu_tag] && !flush;
    assign lsb_hit = rdy && busy[in_lsb_tag] && !flush;
    assign wr_reg = do_commit && !h_store && !h_branch;
    assign redirect = (h_jalr || taken_q[head]) ? target_q[head] : pc_q[head] + 32'd4;
    assign out_fetch_ready1 = busy[in_fetch_tag1] && (ready[in_fetch_tag1] || in_fetch_tag1 == in_alu_tag || in_fetch_tag1 == in_lsb_tag);
    assign out_fetch_ready2 = busy[in_fetch_tag2] && (ready[in_fetch_tag2] || in_fetch_tag2 == in_alu_tag || in_fetch_tag2 == in_lsb_tag);
    assign out_fetch_value1 = !busy[in_fetch_tag1] ? '0 : ready[in_fetch_tag1] ? val_q[in_fetch_tag1] : in_fetch_tag1 == in_alu_tag ? in_alu_value : in_fetch_tag1 == in_lsb_tag ? in_lsb_value : '0;
    assign out_fetch_value2 = !busy[in_fetch_tag2] ? '0 : ready[in_fetch_tag2] ? val_q[in_fetch_tag2] : in_fetch_tag2 == in_alu_tag ? in_alu_value : in_fetch_tag2 == in_lsb_tag ? in_lsb_value : '0;
    // Pointers, occupancy and per-entry busy/ready flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head <= TAG_W'(1);
            tail <= TAG_W'(1);
            count <= '0;
            busy <= '0;
            ready <= '0;
        end else if (flush) begin
            head <= TAG_W'(1);
            tail <= TAG_W'(1);
            count <= '0;
            busy <= '0;
            ready <= '0;
        end else if (rdy) begin
            if (do_commit) begin
                busy[head] <= 1'b0;
                head <= rob_next(head, ROB_SIZE);
            end
            if (lsb_hit) ready[in_lsb_tag] <= 1'b1;
            if (alu_hit) ready[in_alu_tag] <= 1'b1;
            if (do_issue) begin
                busy[tail] <= 1'b1;
                ready[tail] <= 1'b0;
                tail <= rob_next(tail, ROB_SIZE);
            end
            count <= count + CNT_W'(do_issue) - CNT_W'(do_commit);
        end
    end
    // Entry payload; only meaningful while the matching busy bit is set
    always_ff @(posedge clk) begin
        if (do_issue) begin
            op_q[tail] <= in_dcd_op;
            dest_q[tail] <= in_dcd_dest;
            pc_q[tail] <= in_dcd_pc;
            pred_q[tail] <= in_dcd_jump_flag;
        end
        if (lsb_hit) val_q[in_lsb_tag] <= in_lsb_value;
        if (alu_hit) begin
            val_q[in_alu_tag] <= in_alu_value;
            taken_q[in_alu_tag] <= in_alu_taken;
            target_q[in_alu_tag] <= in_alu_target;
        end
    end
    // Registered retire/flush pulses, zero unless an entry retires on this edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_commit_dest <= ZERO_REG;
            out_commit_tag <= ZERO_ROB;
            out_commit_value <= '0;
            out_store_commit_tag <= ZERO_ROB;
            out_flush <= 1'b0;
            out_redirect_pc <= '0;
        end else begin
            out_commit_dest <= wr_reg ? dest_q[head] : ZERO_REG;
            out_commit_tag <= wr_reg ? head : ZERO_ROB;
            out_commit_value <= wr_reg ? val_q[head] : '0;
            out_store_commit_tag <= (do_commit && h_store) ? head : ZERO_ROB;
            out_flush <= flush;
            out_redirect_pc <= flush ? redirect : '0;
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed checks of issue, broadcast, bypass, retire, flush, full and reset
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;
    logic clk = 1'b0, rst = 1'b0, rdy = 1'b1;
    logic [5:0] in_dcd_op;
    logic [4:0] in_dcd_dest;
    logic [31:0] in_dcd_pc;
    logic in_dcd_jump_flag;
    logic [3:0] out_freetag, in_fetch_tag1, in_fetch_tag2, in_alu_tag, in_lsb_tag;
    logic out_full, out_fetch_ready1, out_fetch_ready2, in_alu_taken, out_flush;
    logic [31:0] out_fetch_value1, out_fetch_value2, in_alu_value, in_alu_target, in_lsb_value;
    logic [4:0] out_commit_dest;
    logic [3:0] out_commit_tag, out_store_commit_tag;
    logic [31:0] out_commit_value, out_redirect_pc;
    int n_checks = 0, n_fail = 0;

    reorder_buffer dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .in_dcd_op(in_dcd_op), .in_dcd_dest(in_dcd_dest), .in_dcd_pc(in_dcd_pc),
        .in_dcd_jump_flag(in_dcd_jump_flag), .out_freetag(out_freetag), .out_full(out_full),
        .in_fetch_tag1(in_fetch_tag1), .in_fetch_tag2(in_fetch_tag2),
        .out_fetch_value1(out_fetch_value1), .out_fetch_value2(out_fetch_value2),
        .out_fetch_ready1(out_fetch_ready1), .out_fetch_ready2(out_fetch_ready2),
        .in_alu_tag(in_alu_tag), .in_alu_value(in_alu_value), .in_alu_taken(in_alu_taken),
        .in_alu_target(in_alu_target), .in_lsb_tag(in_lsb_tag), .in_lsb_value(in_lsb_value),
        .out_commit_dest(out_commit_dest), .out_commit_tag(out_commit_tag),
        .out_commit_value(out_commit_value), .out_store_commit_tag(out_store_commit_tag),
        .out_flush(out_flush), .out_redirect_pc(out_redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        in_dcd_op = OPENUM_NOP;
        in_dcd_dest = '0;
        in_dcd_pc = '0;
        in_dcd_jump_flag = 1'b0;
        in_fetch_tag1 = '0;
        in_fetch_tag2 = '0;
        in_alu_tag = '0;
        in_alu_value = '0;
        in_alu_taken = 1'b0;
        in_alu_target = '0;
        in_lsb_tag = '0;
        in_lsb_value = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] op, input logic [4:0] d, input logic [31:0] pc, input logic pj);
        in_dcd_op = op;
        in_dcd_dest = d;
        in_dcd_pc = pc;
        in_dcd_jump_flag = pj;
        tick();
        idle();
    endtask

    task automatic alu(input logic [3:0] t, input logic [31:0] v, input logic tk, input logic [31:0] tg);
        in_alu_tag = t;
        in_alu_value = v;
        in_alu_taken = tk;
        in_alu_target = tg;
    endtask

    initial begin
        idle();
        tick();
        tick();
        chk("reset_freetag", 32'(out_freetag), 32'd1);
        chk("reset_full", 32'(out_full), 32'd0);
        chk("reset_dest", 32'(out_commit_dest), 32'd0);
        chk("reset_flush", 32'(out_flush), 32'd0);
        chk("reset_store", 32'(out_store_commit_tag), 32'd0);
        rst = 1'b1;
        tick();
        // ADD dest 5 at tag 1, ALU result 0x2A, bypass seen on query
        chk("t1_freetag_pre", 32'(out_freetag), 32'd1);
        issue(OPENUM_ADD, 5'd5, 32'h0, 1'b0);
        chk("t1_freetag_post", 32'(out_freetag), 32'd2);
        alu(4'd1, 32'h2A, 1'b0, 32'h0);
        in_fetch_tag1 = 4'd1;
        #1;
        chk("t1_bypass_rdy", 32'(out_fetch_ready1), 32'd1);
        chk("t1_bypass_val", out_fetch_value1, 32'h2A);
        tick();
        idle();
        chk("t1_no_commit_yet", 32'(out_commit_dest), 32'd0);
        tick();
        chk("t1_commit_dest", 32'(out_commit_dest), 32'd5);
        chk("t1_commit_tag", 32'(out_commit_tag), 32'd1);
        chk("t1_commit_val", out_commit_value, 32'h2A);
        tick();
        chk("t1_commit_clear", 32'(out_commit_dest), 32'd0);
        // rdy low holds state: issue attempt ignored
        rdy = 1'b0;
        in_dcd_op = OPENUM_ADD;
        in_dcd_dest = 5'd1;
        tick();
        rdy = 1'b1;
        idle();
        chk("rdy_hold_freetag", 32'(out_freetag), 32'd2);
        // SW at tag 2, ADD dest 9 at tag 3; bypass on tag 3, store retire
        issue(OPENUM_SW, 5'd0, 32'h10, 1'b0);
        issue(OPENUM_ADD, 5'd9, 32'h14, 1'b0);
        chk("t2_freetag", 32'(out_freetag), 32'd4);
        alu(4'd3, 32'h77, 1'b0, 32'h0);
        in_fetch_tag1 = 4'd3;
        in_fetch_tag2 = 4'd2;
        #1;
        chk("t2_bypass_rdy", 32'(out_fetch_ready1), 32'd1);
        chk("t2_bypass_val", out_fetch_value1, 32'h77);
        chk("t2_notready_rdy", 32'(out_fetch_ready2), 32'd0);
        chk("t2_notready_val", out_fetch_value2, 32'h0);
        tick();
        idle();
        in_fetch_tag1 = 4'd3;
        #1;
        chk("t2_stored_rdy", 32'(out_fetch_ready1), 32'd1);
        chk("t2_stored_val", out_fetch_value1, 32'h77);
        chk("t2_tag0_rdy", 32'(out_fetch_ready2), 32'd0);
        chk("t2_head_blocks", 32'(out_commit_tag), 32'd0);
        in_lsb_tag = 4'd2;
        in_lsb_value = 32'hDEAD;
        tick();
        idle();
        tick();
        chk("t2_store_tag", 32'(out_store_commit_tag), 32'd2);
        chk("t2_store_dest", 32'(out_commit_dest), 32'd0);
        chk("t2_store_ctag", 32'(out_commit_tag), 32'd0);
        tick();
        chk("t2_add_dest", 32'(out_commit_dest), 32'd9);
        chk("t2_add_tag", 32'(out_commit_tag), 32'd3);
        chk("t2_add_val", out_commit_value, 32'h77);
        chk("t2_add_store", 32'(out_store_commit_tag), 32'd0);
        tick();
        // JALR at tag 4 always redirects to target and writes link value
        issue(OPENUM_JALR, 5'd1, 32'h300, 1'b0);
        alu(4'd4, 32'h304, 1'b1, 32'h400);
        tick();
        idle();
        tick();
        chk("jalr_dest", 32'(out_commit_dest), 32'd1);
        chk("jalr_val", out_commit_value, 32'h304);
        chk("jalr_flush", 32'(out_flush), 32'd1);
        chk("jalr_redirect", out_redirect_pc, 32'h400);
        chk("jalr_freetag", 32'(out_freetag), 32'd1);
        tick();
        chk("jalr_flush_pulse", 32'(out_flush), 32'd0);
        // BEQ predicted taken, resolved not taken: flush to pc+4
        issue(OPENUM_BEQ, 5'd0, 32'h100, 1'b1);
        issue(OPENUM_ADD, 5'd3, 32'h104, 1'b0);
        issue(OPENUM_ADD, 5'd4, 32'h108, 1'b0);
        chk("beq_freetag_pre", 32'(out_freetag), 32'd4);
        alu(4'd1, 32'h0, 1'b0, 32'h200);
        tick();
        idle();
        in_dcd_op = OPENUM_ADD;
        in_dcd_dest = 5'd6;
        alu(4'd2, 32'h55, 1'b0, 32'h0);
        tick();
        idle();
        chk("beq_flush", 32'(out_flush), 32'd1);
        chk("beq_redirect", out_redirect_pc, 32'h104);
        chk("beq_freetag", 32'(out_freetag), 32'd1);
        chk("beq_dest", 32'(out_commit_dest), 32'd0);
        chk("beq_ctag", 32'(out_commit_tag), 32'd0);
        in_fetch_tag1 = 4'd2;
        #1;
        chk("beq_younger_gone", 32'(out_fetch_ready1), 32'd0);
        tick();
        chk("beq_flush_pulse", 32'(out_flush), 32'd0);
        chk("beq_redirect_clr", out_redirect_pc, 32'h0);
        // Fill all 15 entries, 16th ignored, retire one and see wrapped freetag
        for (int i = 1; i <= 15; i++) issue(OPENUM_ADD, 5'(i), 32'(i * 4), 1'b0);
        chk("full_flag", 32'(out_full), 32'd1);
        chk("full_freetag", 32'(out_freetag), 32'd0);
        in_dcd_op = OPENUM_ADD;
        in_dcd_dest = 5'd20;
        alu(4'd1, 32'h11, 1'b0, 32'h0);
        tick();
        idle();
        chk("full_16th_ignored", 32'(out_full), 32'd1);
        in_dcd_op = OPENUM_ADD;
        in_dcd_dest = 5'd21;
        alu(4'd2, 32'h22, 1'b0, 32'h0);
        tick();
        idle();
        chk("full_commit_dest", 32'(out_commit_dest), 32'd1);
        chk("full_commit_tag", 32'(out_commit_tag), 32'd1);
        chk("full_commit_val", out_commit_value, 32'h11);
        chk("full_clear", 32'(out_full), 32'd0);
        chk("full_wrap_freetag", 32'(out_freetag), 32'd1);
        // Asynchronous reset with 14 entries pending and head ready to retire
        rst = 1'b0;
        #1;
        chk("rst_dest", 32'(out_commit_dest), 32'd0);
        chk("rst_tag", 32'(out_commit_tag), 32'd0);
        chk("rst_val", out_commit_value, 32'h0);
        chk("rst_freetag", 32'(out_freetag), 32'd1);
        chk("rst_full", 32'(out_full), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("rst_after_tag", 32'(out_commit_tag), 32'd0);
        tick();
        chk("rst_after_tag2", 32'(out_commit_tag), 32'd0);
        chk("rst_after_flush", 32'(out_flush), 32'd0);
        in_fetch_tag1 = 4'd2;
        #1;
        chk("rst_entry_gone", 32'(out_fetch_ready1), 32'd0);
        idle();
        issue(OPENUM_ADD, 5'd2, 32'h0, 1'b0);
        chk("rst_count_zero", 32'(out_freetag), 32'd2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
